// File: rtl/uart_rx_if.sv
// Byte-side handshake and status bundle of the UART receiver.
// master = receiver (drives data/flags), slave = byte consumer.
`timescale 1ns/1ps
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (output rx_data, output rx_valid, output frame_err, output overrun,
                  input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  overrun,
                  output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, centre-sampling FSM and a
// valid/ready holding register with one-cycle frame_err / overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  uart_rx_if.master  rx
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic        rxd_meta_q;
  logic        rxs_q;
  state_e      state_q,     state_d;
  logic [15:0] cnt_q,       cnt_d;
  logic [2:0]  bit_idx_q,   bit_idx_d;
  logic [7:0]  shreg_q,     shreg_d;
  logic [7:0]  rx_data_q,   rx_data_d;
  logic        rx_valid_q,  rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q,   overrun_d;

  // Synchronizer idles high so reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxs_q      <= rxd_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx.rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxs_q, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) state_d   = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            // A byte loads only into an empty register or one being read this cycle.
            if (!rx_valid_q || rx.rx_ready) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d  = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx.rx_data   = rx_data_q;
  assign rx.rx_valid  = rx_valid_q;
  assign rx.frame_err = frame_err_q;
  assign rx.overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive stage for the UART link: recovers 8N1 frames from the asynchronous `rxd` line, samples each bit at its centre, and presents each received byte on a valid/ready holding register. It pairs with the transmitter stage and uses the same bit timing: 5208 clocks per bit, which is 9600 baud at 50 MHz. Its output feeds the byte-level consumer logic.

## Interface
- `CLKS_PER_BIT`, default 5208: clocks per serial bit. Legal range 8..65535.
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `rst` input, 1 bit: **synchronous, active-high reset**. Sampled on the `clk` rising edge.
- `rxd` input, 1 bit: asynchronous serial line. Idles high.
- `rx_data` output, 8 bits: received byte. Valid while `rx_valid` is high.
- `rx_valid` output, 1 bit: the holding register contains an unread byte.
- `rx_ready` input, 1 bit: consumer accepts the byte. A transfer happens on a cycle where `rx_valid` and `rx_ready` are both high.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `overrun` output, 1 bit: one-cycle pulse when a completed byte is dropped because the holding register is full.

## Operation
- Input conditioning: `rxd` passes through a 2-flop synchronizer. Its reset value is 1. All FSM decisions use the synchronized signal `rxs`.
- Bit counter: `cnt`, 16 bits. Bit index: `bit_idx`, 3 bits. Shift register: `shreg`, 8 bits. Data is received LSB first; each sampled bit shifts in at bit 7 and the register shifts right.
- States:
  - IDLE: `cnt`=0. Go to START on `rxs`=0.
  - START: count `cnt` from 0 to CLKS_PER_BIT/2−1 (integer division).
    - At terminal count, if `rxs`=0, go to DATA with `cnt`=0 and `bit_idx`=0.
    - At terminal count, if `rxs`=1, this is a false start: go back to IDLE. No flags are raised.
  - DATA: count `cnt` from 0 to CLKS_PER_BIT−1.
    - At terminal count, sample `rxs` into `shreg` and reset `cnt` to 0.
    - If `bit_idx`=7, go to STOP. Otherwise increment `bit_idx`.
  - STOP: count `cnt` from 0 to CLKS_PER_BIT−1, then sample `rxs`.
    - If `rxs`=1: perform the frame-complete action (below) and go to IDLE.
    - If `rxs`=0: pulse `frame_err`, discard `shreg`, and go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Frame complete:
  - If `rx_valid`=0, or `rx_ready`=1 in the same cycle: load `rx_data` ← `shreg` and set `rx_valid`=1.
  - Otherwise pulse `overrun`. The old `rx_data` and `rx_valid` are kept and the new byte is lost.
- Handshake: `rx_valid` clears on the cycle after a transfer, unless a new byte loads in that same cycle. `rx_data` is stable whenever `rx_valid`=1 and no transfer occurs.
- Reset: while `rst`=1, the FSM is forced to IDLE on every clock edge, even mid-frame. A partial frame is discarded. Receiving resumes at the next falling edge after `rst` is released.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `overrun`=0. Synchronizer flops reset to 1. FSM resets to IDLE, `cnt`=0, `bit_idx`=0.
- Input delay: 2 cycles from an `rxd` change to `rxs`.
- Sample points: all samples are taken relative to the `rxs` falling edge (cycle E).
  - Start-bit check at E + CLKS_PER_BIT/2.
  - Data bit k sampled at E + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Stop bit sampled at E + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- Output latency: `rx_valid`, `frame_err` and `overrun` are registered and change on the cycle after the stop sample.
- Back-to-back frames: IDLE is re-entered the cycle after the stop sample. The next start edge is detected from that point, so 9.5-bit centre sampling tolerates at least ±4% baud mismatch.
- Flags: `frame_err` and `overrun` are never both high in the same cycle. Each is exactly 1 cycle wide.

## Test plan
Simulation runs with CLKS_PER_BIT=16.
- Single byte: drive 8'h55 frame, `rx_ready`=0 → `rx_valid` rises 1 cycle after the stop sample, `rx_data`=8'h55, held until `rx_ready` is pulsed; `rx_valid`=0 the next cycle.
- Back-to-back frames: send 8'hA5 then 8'h3C with no idle gap, `rx_ready` held at 1 → two valid bytes, in order, with no `overrun`.
- Glitch: drive `rxd` low for 6 clocks, then high → no `rx_valid` and no flags; then a valid 8'h81 frame is received correctly.
- Framing error: 8'hF0 frame with stop bit = 0, then line held low for 40 clocks → a single `frame_err` pulse, no `rx_valid`, no new frame until `rxd` returns high; then 8'h12 is received.
- Overrun: receive 8'h11 with `rx_ready`=0, then 8'h22 → `overrun` pulses once, `rx_data` stays 8'h11.
- Reset mid-operation: assert `rst` for 2 cycles mid-frame (during bit 4) → all outputs return to reset values, the partial frame is discarded, and the next full frame 8'h7E is received correctly.
